// File: rtl/aes_arb_pkg.sv
// aes_arb_pkg: shared types and constants for the AES word arbiter
package aes_arb_pkg;
  localparam int NUM_REQ = 4;
  typedef logic [1:0] req_idx_t;
  typedef enum logic {IDLE, BURST} arb_state_e;
endpackage

// File: rtl/aes_word_arbiter_if.sv
// aes_word_arbiter_if: requester-side and output-side handshake bundle of the AES word arbiter
interface aes_word_arbiter_if #(parameter int WIDTH = 32);
  import aes_arb_pkg::*;
  logic [NUM_REQ-1:0] req_valid;
  logic [NUM_REQ*WIDTH-1:0] req_data;
  logic [NUM_REQ-1:0] req_ready;
  req_idx_t sel;
  logic out_valid;
  logic [WIDTH-1:0] out_data;
  logic out_last;
  req_idx_t out_src;
  logic out_ready;
  modport master(output req_valid, req_data, out_ready, input req_ready, sel, out_valid, out_data, out_last, out_src);
  modport slave(input req_valid, req_data, out_ready, output req_ready, sel, out_valid, out_data, out_last, out_src);
endinterface

// File: rtl/aes_word_arbiter_rr_pick4.sv
// aes_rr_pick4: round-robin winner search from last_grant+1; AES_ARB_PRIO0_EN gives requester 0 absolute priority
module aes_rr_pick4 import aes_arb_pkg::*; (
  input  logic [NUM_REQ-1:0] req_i,
  input  req_idx_t           last_grant_i,
  output logic               valid_o,
  output req_idx_t           win_o
);
  logic [NUM_REQ-1:0] rr_req;
  req_idx_t idx;
`ifdef AES_ARB_PRIO0_EN
  assign rr_req = {req_i[NUM_REQ-1:1], 1'b0};
`else
  assign rr_req = req_i;
`endif
  assign valid_o = |req_i;
  // descending scan so the nearest requester after last_grant overrides farther ones
  always_comb begin
    win_o = last_grant_i;
    idx = last_grant_i;
    for (int i = NUM_REQ; i >= 1; i--) begin
      idx = last_grant_i + req_idx_t'(i);
      if (rr_req[idx]) win_o = idx;
    end
`ifdef AES_ARB_PRIO0_EN
    if (req_i[0]) win_o = '0;
`endif
  end
endmodule

// File: rtl/mux_32.sv
// mux_32: 4:1 word mux of the shared AES datapath
module mux_32 #(parameter int WIDTH = 32) (
  input  logic [4*WIDTH-1:0] d_i,
  input  logic [1:0]         sel_i,
  output logic [WIDTH-1:0]   q_o
);
  assign q_o = d_i[sel_i*WIDTH +: WIDTH];
endmodule

// File: rtl/aes_word_arbiter.sv
// aes_word_arbiter: round-robin burst sequencer sharing one AES word datapath among four sources (option AES_ARB_PRIO0_EN)
module aes_word_arbiter #(
  parameter int WIDTH = 32,
  parameter int BURST = 4
) (
  input logic clk,
  input logic rst_n,
  aes_word_arbiter_if.slave bus_if
);
  import aes_arb_pkg::*;
  localparam int CW = BURST > 1 ? $clog2(BURST) : 1;
  arb_state_e state_q;
  req_idx_t grant_q, last_grant_q, out_src_q, win;
  logic [CW-1:0] cnt_q;
  logic [WIDTH-1:0] out_data_q, mux_data;
  logic out_valid_q, out_last_q, pick_valid, in_burst, out_free, accept, last_word;
  aes_rr_pick4 u_pick (
    .req_i(bus_if.req_valid),
    .last_grant_i(last_grant_q),
    .valid_o(pick_valid),
    .win_o(win)
  );
  mux_32 #(.WIDTH(WIDTH)) u_mux (
    .d_i(bus_if.req_data),
    .sel_i(grant_q),
    .q_o(mux_data)
  );
  assign in_burst = state_q == aes_arb_pkg::BURST;
  assign out_free = !out_valid_q || bus_if.out_ready;
  assign accept = in_burst && bus_if.req_valid[grant_q] && out_free;
  assign last_word = cnt_q == CW'(BURST - 1);
  assign bus_if.req_ready = in_burst ? {{(NUM_REQ-1){1'b0}}, out_free} << grant_q : '0;
  assign bus_if.sel = grant_q;
  assign bus_if.out_valid = out_valid_q;
  assign bus_if.out_data = out_data_q;
  assign bus_if.out_last = out_last_q;
  assign bus_if.out_src = out_src_q;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= aes_arb_pkg::IDLE;
      grant_q <= '0;
      last_grant_q <= 2'd3;
      cnt_q <= '0;
      out_valid_q <= 1'b0;
      out_data_q <= '0;
      out_last_q <= 1'b0;
      out_src_q <= '0;
    end else begin
      if (accept) begin
        out_valid_q <= 1'b1;
        out_data_q <= mux_data;
        out_src_q <= grant_q;
        out_last_q <= last_word;
        cnt_q <= last_word ? '0 : cnt_q + 1'b1;
      end else if (bus_if.out_ready) begin
        out_valid_q <= 1'b0;
      end
      if (!in_burst && pick_valid) begin
        grant_q <= win;
        state_q <= aes_arb_pkg::BURST;
      end
      if (accept && last_word) begin
        state_q <= aes_arb_pkg::IDLE;
`ifdef AES_ARB_PRIO0_EN
        if (grant_q != '0) last_grant_q <= grant_q;
`else
        last_grant_q <= grant_q;
`endif
      end
    end
  end
endmodule

// File: tb/tb_aes_word_arbiter.sv
// tb_aes_word_arbiter: scoreboard bench for aes_word_arbiter (honours AES_ARB_PRIO0_EN)
module tb_aes_word_arbiter;
  import aes_arb_pkg::*;
  typedef struct {logic [31:0] d; req_idx_t s; logic l;} exp_t;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  aes_word_arbiter_if #(.WIDTH(32)) bus();
  aes_word_arbiter #(.WIDTH(32), .BURST(4)) dut (.clk(clk), .rst_n(rst_n), .bus_if(bus.slave));
  always #5 clk = ~clk;
  logic [31:0] srcq [4][$];
  bit en [4];
  exp_t sb [$];
  int out_cyc [$];
  int cyc = 0;
  int n_chk = 0;
  int n_pass = 0;
  task automatic chk(string tag, logic [31:0] got, logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h (cycle %0d)", tag, got, exp, cyc);
  endtask
  task automatic drive();
    for (int i = 0; i < 4; i++) begin
      bus.req_valid[i] = en[i] && srcq[i].size() > 0;
      bus.req_data[i*32 +: 32] = srcq[i].size() > 0 ? srcq[i][0] : 32'h0;
    end
  endtask
  task automatic load(int i, logic [31:0] base);
    for (int k = 0; k < 4; k++) begin
      srcq[i].push_back(base + k);
      sb.push_back('{base + k, req_idx_t'(i), k == 3});
    end
    drive();
  endtask
  task automatic step();
    logic [3:0] a;
    exp_t e;
    @(negedge clk);
    a = bus.req_valid & bus.req_ready;
    if (rst_n && bus.out_valid && bus.out_ready) begin
      if (sb.size() == 0) chk("extra_word", bus.out_data, 32'hxxxxxxxx);
      else begin
        e = sb.pop_front();
        chk("data", bus.out_data, e.d);
        chk("src", 32'(bus.out_src), 32'(e.s));
        chk("last", 32'(bus.out_last), 32'(e.l));
      end
      out_cyc.push_back(cyc);
    end
    @(posedge clk);
    #1;
    cyc++;
    for (int i = 0; i < 4; i++) if (rst_n && a[i] && srcq[i].size() > 0) void'(srcq[i].pop_front());
    drive();
  endtask
  function automatic bit pending();
    pending = sb.size() > 0;
    for (int i = 0; i < 4; i++) if (srcq[i].size() > 0) pending = 1'b1;
  endfunction
  task automatic drain();
    int n = 0;
    while (pending() && n < 200) begin
      step();
      n++;
    end
    chk("drain_budget", 32'(n < 200), 32'd1);
  endtask
  task automatic wait_pop(int i, int left);
    int n = 0;
    while (srcq[i].size() > left && n < 50) begin
      step();
      n++;
    end
    chk("accept_budget", 32'(n < 50), 32'd1);
  endtask
  task automatic do_reset();
    rst_n = 1'b0;
    sb.delete();
    for (int i = 0; i < 4; i++) srcq[i].delete();
    drive();
    step();
    rst_n = 1'b1;
  endtask
  initial begin
    int t0, n;
    logic [31:0] held;
    for (int i = 0; i < 4; i++) en[i] = 1'b1;
    bus.out_ready = 1'b1;
    drive();
    #2;
    chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
    chk("rst_req_ready", 32'(bus.req_ready), 32'd0);
    chk("rst_sel", 32'(bus.sel), 32'd0);
    chk("rst_out_data", bus.out_data, 32'd0);
    chk("rst_out_last", 32'(bus.out_last), 32'd0);
    chk("rst_out_src", 32'(bus.out_src), 32'd0);
    step();
    rst_n = 1'b1;
    // single requester: words 1..4, first output two cycles after the request
    t0 = cyc;
    out_cyc.delete();
    load(0, 32'h1);
    drain();
    chk("first_latency", out_cyc.size() > 0 ? 32'(out_cyc[0] - t0) : 32'hffffffff, 32'd2);
    // all four requesting continuously
    do_reset();
    out_cyc.delete();
`ifdef AES_ARB_PRIO0_EN
    load(0, 32'h100); load(0, 32'h500); load(1, 32'h200); load(2, 32'h300); load(3, 32'h400);
`else
    load(0, 32'h100); load(1, 32'h200); load(2, 32'h300); load(3, 32'h400); load(0, 32'h500);
`endif
    drain();
    chk("rr_words", 32'(out_cyc.size()), 32'd20);
    if (out_cyc.size() == 20) begin
      chk("burst_span", 32'(out_cyc[3] - out_cyc[0]), 32'd3);
      chk("period_01", 32'(out_cyc[4] - out_cyc[0]), 32'd5);
      chk("period_12", 32'(out_cyc[8] - out_cyc[4]), 32'd5);
      chk("period_34", 32'(out_cyc[16] - out_cyc[12]), 32'd5);
    end
    // backpressure after the first word
    load(1, 32'h600);
    n = 0;
    while (!bus.out_valid && n < 20) begin
      step();
      n++;
    end
    chk("bp_wait", 32'(n < 20), 32'd1);
    bus.out_ready = 1'b0;
    held = bus.out_data;
    chk("bp_first", held, 32'h600);
    repeat (3) begin
      step();
      chk("bp_req_ready", 32'(bus.req_ready), 32'd0);
      chk("bp_hold", bus.out_data, held);
      chk("bp_valid", 32'(bus.out_valid), 32'd1);
    end
    bus.out_ready = 1'b1;
    drain();
    // granted requester 0 stalls after two words while 2 waits
    do_reset();
    load(0, 32'h700);
    load(2, 32'h800);
    wait_pop(0, 2);
    en[0] = 1'b0;
    drive();
    repeat (5) begin
      step();
      chk("stall_sel", 32'(bus.sel), 32'd0);
      chk("stall_ready2", 32'(bus.req_ready[2]), 32'd0);
    end
    chk("stall_idle_out", 32'(bus.out_valid), 32'd0);
    chk("stall_r2_pending", 32'(srcq[2].size()), 32'd4);
    en[0] = 1'b1;
    drive();
    drain();
    // reset after the second word of a burst
    load(1, 32'h900);
    wait_pop(1, 2);
    chk("pre_rst_valid", 32'(bus.out_valid), 32'd1);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_valid", 32'(bus.out_valid), 32'd0);
    chk("mid_rst_ready", 32'(bus.req_ready), 32'd0);
    chk("mid_rst_sel", 32'(bus.sel), 32'd0);
    sb.delete();
    for (int i = 0; i < 4; i++) srcq[i].delete();
    drive();
    step();
    rst_n = 1'b1;
    load(0, 32'hB00);
    load(2, 32'hA00);
    drain();
    // requesters 0 and 2 both valid after a burst by 0
    load(0, 32'hC00);
    drain();
`ifdef AES_ARB_PRIO0_EN
    load(0, 32'hD00);
    load(2, 32'hE00);
`else
    load(2, 32'hE00);
    load(0, 32'hD00);
`endif
    drain();
    chk("sb_empty", 32'(sb.size()), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule

// File: doc/aes_word_arbiter.md
# aes_word_arbiter

Round-robin arbiter and sequencer that shares one 32-bit AES word datapath among four requesters. Each grant transfers one burst of BURST words (default 4, one 128-bit AES block as four columns) from the winning requester into a registered output stage. The block drives the 4:1 word-mux select for the shared datapath. It sits between the block-input sources (key load, plaintext, IV, test port) and the round engine.

## Interface
- WIDTH, 32: word width in bits.
- BURST, 4: words per grant; legal range is 1..16.
- clk  in  1  system clock; all state changes on its rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- req_valid  in  4  per-requester word valid.
- req_data  in  4*WIDTH  packed words; requester i occupies bits [i*WIDTH +: WIDTH].
- req_ready  out  4  per-requester accept; at most one bit is high.
- sel  out  2  current grant index, driven to the shared 4:1 word mux.
- out_valid  out  1  output word valid.
- out_data  out  WIDTH  output word.
- out_last  out  1  marks the final word of a burst.
- out_src  out  2  index of the requester that sourced the word.
- out_ready  in  1  downstream accept.

## Operation
- States:
  - IDLE: no grant held.
  - BURST: grant locked to one requester.
- IDLE:
  - If any req_valid bit is high, register the winner in grant and go to BURST.
  - The winner is the first requester with req_valid high, searching upward from (last_grant+1) mod 4.
  - req_ready is 0 in IDLE.
- BURST:
  - sel equals grant.
  - req_ready[grant] = !out_valid || out_ready. All other req_ready bits are 0.
  - Word accepted when req_valid[grant] && req_ready[grant]. On accept:
    - out_data ← req_data[grant]
    - out_src ← grant
    - out_last ← (cnt == BURST-1)
    - out_valid ← 1
    - cnt increments
  - On accepting word BURST-1: cnt ← 0, last_grant ← grant, state ← IDLE.
- Output register:
  - When out_valid && out_ready and no new word is accepted, out_valid ← 0.
  - out_data and out_src hold their values while out_valid && !out_ready.
- cnt width is max(1, $clog2(BURST)). cnt does not wrap beyond BURST-1.
- The granted requester dropping req_valid mid-burst: the grant is held indefinitely and no other requester is served. There is no timeout.
- Requests from other requesters during BURST are ignored until IDLE.

## Timing
- Reset values:
  - state IDLE, grant 0, sel 0, cnt 0, last_grant 3 (so requester 0 wins first)
  - req_ready 0, out_valid 0, out_data 0, out_last 0, out_src 0
- Arbitration costs 1 cycle: req_valid seen in IDLE at cycle N → first possible accept at cycle N+1.
- Acceptance to out_valid: 1 cycle.
- Sustained throughput within a burst is 1 word/cycle when out_ready stays high.
- Minimum burst period is BURST+1 cycles (one IDLE cycle between bursts).
- Reset asserted mid-burst: all state returns to reset values immediately. The partial burst is dropped and out_valid falls asynchronously.
- Simultaneous final accept and a new request: the new request is arbitrated in the following IDLE cycle.

## Configuration
- AES_ARB_PRIO0_EN defined:
  - In IDLE, requester 0 wins whenever req_valid[0] is high (key load has absolute priority).
  - Requesters 1–3 are round-robin among themselves, using last_grant among 1–3.
  - Bursts in progress are never pre-empted.
- AES_ARB_PRIO0_EN undefined: pure 4-way round robin as described in Operation.

## Structure
- Shared package aes_arb_pkg contains:
  - NUM_REQ = 4
  - typedef logic [1:0] req_idx_t
  - state enum arb_state_e {IDLE, BURST}
- One sub-module, aes_rr_pick4: combinational. Inputs are 4-bit req and last_grant; outputs are a valid flag and the winner index. The AES_ARB_PRIO0_EN override is applied inside it.
- The data path selection is the existing 4:1 word mux mux_32, driven by sel.

## Test plan
- Single requester: req_valid=4'b0001, words A0..A3=32'h00000001..32'h00000004, out_ready=1.
  - Expect out_data sequence 1,2,3,4 with out_src=0 and out_last only on 4.
  - Expect the first out_valid 2 cycles after the request is seen.
- All four requesting continuously:
  - Expect grant order 0,1,2,3,0.
  - Each burst is 4 words followed by one IDLE gap, for a 5-cycle period.
- Backpressure: out_ready=0 for 3 cycles after the first word.
  - Expect req_ready[grant]=0 and out_data held at its value.
  - Expect no word loss and no duplication once out_ready returns.
- Granted requester drops req_valid after 2 words while requester 2 is pending.
  - Expect the grant to stay fixed and sel unchanged.
  - Expect requester 2 to be served only after words 3 and 4 complete.
- rst_n pulsed low after the second burst word.
  - Expect out_valid=0 and req_ready=0.
  - Next request: requester 0 wins if it is requesting; the new burst count restarts at 0.
- With AES_ARB_PRIO0_EN and requesters 0 and 2 both valid after a burst by 0:
  - Expect requester 0 granted again (without the macro, 2 is granted).
